// File: rtl/mips_control_monitor.sv
// Passive monitor for the multicycle MIPS control FSM: decodes each control word
// back to its FSM state, checks the transition against the opcode, and counts work.
module mips_control_monitor #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemWrite,
  input  logic             IRWrite,
  input  logic             MemtoReg,
  input  logic             RegDst,
  input  logic             RegWrite,
  input  logic             ALUSrcA,
  input  logic [2:0]       ALUSrcB,
  input  logic [1:0]       ALUOp,
  input  logic [1:0]       PCSource,
  input  logic             PCWriteCond,
  input  logic             PCWrite,
  input  logic             IorD,
  input  logic [5:0]       Op_code,
  output logic [3:0]       state_id,
  output logic             state_valid,
  output logic             instr_done,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic             err,
  output logic [1:0]       err_code
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [3:0] NO_STATE = 4'hF;

  // TRACK: check against exp_state; WAIT_S0: resync after a garbage word;
  // ANY_NEXT: follow whatever comes after an unknown opcode.
  typedef enum logic [1:0] {TRACK, WAIT_S0, ANY_NEXT} mode_t;

  mode_t       mode, mode_nxt;
  logic [3:0]  exp_state, exp_nxt;
  logic [5:0]  op_latch, op_nxt;
  logic [4:0]  en;
  logic [9:0]  row;
  logic        hit;
  logic [3:0]  hit_id;
  logic        err_illegal, err_trans, err_op, err_now, done_now;
  logic [1:0]  code_now;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign en = {MemWrite, IRWrite, RegWrite, PCWrite, PCWriteCond};

  always_comb begin
    row[0] = (en == 5'b01010) && !IorD && !ALUSrcA && (ALUSrcB == 3'b001) &&
             (ALUOp == 2'b00) && (PCSource == 2'b00);
    row[1] = (en == 5'b00000) && !ALUSrcA && (ALUSrcB == 3'b011) && (ALUOp == 2'b00);
    row[2] = (en == 5'b00000) && ALUSrcA && (ALUSrcB == 3'b010) && (ALUOp == 2'b00);
    row[3] = (en == 5'b00000) && IorD;
    row[4] = (en == 5'b00100) && !RegDst && MemtoReg;
    row[5] = (en == 5'b10000) && IorD;
    row[6] = (en == 5'b00000) && ALUSrcA && (ALUSrcB == 3'b000) && (ALUOp == 2'b10);
    row[7] = (en == 5'b00100) && RegDst && !MemtoReg;
    row[8] = (en == 5'b00001) && ALUSrcA && (ALUSrcB == 3'b000) && (ALUOp == 2'b01) &&
             (PCSource == 2'b01);
    row[9] = (en == 5'b00010) && (PCSource == 2'b10);
  end

  // S3 only needs IorD, so it ranks below the ALU-setup states it can overlap.
  always_comb begin
    hit    = 1'b1;
    hit_id = NO_STATE;
    if      (row[0]) hit_id = 4'd0;
    else if (row[1]) hit_id = 4'd1;
    else if (row[2]) hit_id = 4'd2;
    else if (row[6]) hit_id = 4'd6;
    else if (row[3]) hit_id = 4'd3;
    else if (row[4]) hit_id = 4'd4;
    else if (row[5]) hit_id = 4'd5;
    else if (row[7]) hit_id = 4'd7;
    else if (row[8]) hit_id = 4'd8;
    else if (row[9]) hit_id = 4'd9;
    else             hit    = 1'b0;
  end

  always_comb begin
    mode_nxt    = mode;
    exp_nxt     = exp_state;
    op_nxt      = op_latch;
    err_illegal = 1'b0;
    err_trans   = 1'b0;
    err_op      = 1'b0;
    if (!hit) begin
      err_illegal = 1'b1;
      mode_nxt    = WAIT_S0;
    end else begin
      if (hit_id == 4'd1) op_nxt = Op_code;
      if (mode == TRACK && hit_id != exp_state) err_trans = 1'b1;
      if (mode != WAIT_S0 || hit_id == 4'd0) begin
        mode_nxt = TRACK;
        case (hit_id)
          4'd0: exp_nxt = 4'd1;
          4'd1: begin
            case (Op_code)
              OP_LW, OP_SW: exp_nxt = 4'd2;
              OP_RTYPE:     exp_nxt = 4'd6;
              OP_BEQ:       exp_nxt = 4'd8;
              OP_J:         exp_nxt = 4'd9;
              default: begin
                err_op   = 1'b1;
                mode_nxt = ANY_NEXT;
              end
            endcase
          end
          4'd2: begin
            case (op_latch)
              OP_LW:   exp_nxt = 4'd3;
              OP_SW:   exp_nxt = 4'd5;
              default: mode_nxt = ANY_NEXT;
            endcase
          end
          4'd3:    exp_nxt = 4'd4;
          4'd6:    exp_nxt = 4'd7;
          default: exp_nxt = 4'd0;
        endcase
      end
    end
  end

  always_comb begin
    err_now  = err_illegal || err_trans || err_op;
    code_now = err_illegal ? 2'b01 : (err_trans ? 2'b10 : (err_op ? 2'b11 : 2'b00));
    done_now = hit && !err_now &&
               (hit_id == 4'd4 || hit_id == 4'd5 || hit_id == 4'd7 ||
                hit_id == 4'd8 || hit_id == 4'd9);
  end

  // Single register stage: every output reflects the word from the previous cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode        <= TRACK;
      exp_state   <= 4'd0;
      op_latch    <= 6'd0;
      state_id    <= NO_STATE;
      state_valid <= 1'b0;
      instr_done  <= 1'b0;
      retire_cnt  <= '0;
      cycle_cnt   <= '0;
      err         <= 1'b0;
      err_code    <= 2'b00;
    end else begin
      mode        <= mode_nxt;
      exp_state   <= exp_nxt;
      op_latch    <= op_nxt;
      state_id    <= hit_id;
      state_valid <= hit;
      instr_done  <= done_now;
      cycle_cnt   <= sat_inc(cycle_cnt);
      if (done_now) retire_cnt <= sat_inc(retire_cnt);
      if (err_now && !err) begin
        err      <= 1'b1;
        err_code <= code_now;
      end
    end
  end

endmodule

// File: tb/tb_mips_control_monitor.sv
// Scoreboard bench for mips_control_monitor: drives FSM control words and checks
// the decoded state stream, error flags and counters.
module tb_mips_control_monitor;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam int         BAD      = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [2:0]  ALUSrcB;
  logic [1:0]  ALUOp, PCSource;
  logic        PCWriteCond, PCWrite, IorD;
  logic [5:0]  Op_code;

  logic [3:0]  state_id, state_id_s;
  logic        state_valid, state_valid_s, instr_done, instr_done_s;
  logic [15:0] retire_cnt, cycle_cnt;
  logic [3:0]  retire_cnt_s, cycle_cnt_s;
  logic        err, err_s;
  logic [1:0]  err_code, err_code_s;

  int n_checks = 0;
  int n_errors = 0;
  logic [5:0] exp_q[$];

  mips_control_monitor u_dut (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .PCWriteCond(PCWriteCond), .PCWrite(PCWrite),
    .IorD(IorD), .Op_code(Op_code), .state_id(state_id), .state_valid(state_valid),
    .instr_done(instr_done), .retire_cnt(retire_cnt), .cycle_cnt(cycle_cnt),
    .err(err), .err_code(err_code)
  );

  mips_control_monitor #(.CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .PCSource(PCSource), .PCWriteCond(PCWriteCond), .PCWrite(PCWrite),
    .IorD(IorD), .Op_code(Op_code), .state_id(state_id_s), .state_valid(state_valid_s),
    .instr_done(instr_done_s), .retire_cnt(retire_cnt_s), .cycle_cnt(cycle_cnt_s),
    .err(err_s), .err_code(err_code_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic drive_state(input int s);
    {MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA} = '0;
    {ALUSrcB, ALUOp, PCSource, PCWriteCond, PCWrite, IorD} = '0;
    case (s)
      0: begin IRWrite = 1; PCWrite = 1; ALUSrcB = 3'b001; end
      1: ALUSrcB = 3'b011;
      2: begin ALUSrcA = 1; ALUSrcB = 3'b010; end
      3: IorD = 1;
      4: begin RegWrite = 1; MemtoReg = 1; end
      5: begin MemWrite = 1; IorD = 1; end
      6: begin ALUSrcA = 1; ALUOp = 2'b10; end
      7: begin RegWrite = 1; RegDst = 1; end
      8: begin PCWriteCond = 1; ALUSrcA = 1; ALUOp = 2'b01; PCSource = 2'b01; end
      9: begin PCWrite = 1; PCSource = 2'b10; end
      default: begin IRWrite = 1; MemWrite = 1; RegWrite = 1; end
    endcase
  endtask

  // Drive one word, queue the expected decode, then pop and compare after the edge.
  task automatic step(input int s, input logic [5:0] op, input logic done);
    logic [5:0] e;
    drive_state(s);
    Op_code = op;
    if (s == BAD) exp_q.push_back({4'hF, 1'b0, 1'b0});
    else          exp_q.push_back({s[3:0], 1'b1, done});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("state_id", {28'd0, state_id}, {28'd0, e[5:2]});
      check("state_valid", {31'd0, state_valid}, {31'd0, e[1]});
      check("instr_done", {31'd0, instr_done}, {31'd0, e[0]});
    end
  endtask

  task automatic do_reset();
    drive_state(0);
    Op_code = OP_RTYPE;
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_state(0);
    Op_code = OP_RTYPE;
    #2 rst = 1'b0;
    #1;
    check("rst_state_id", {28'd0, state_id}, 32'hF);
    check("rst_valid", {31'd0, state_valid}, 32'd0);
    check("rst_done", {31'd0, instr_done}, 32'd0);
    check("rst_retire", {16'd0, retire_cnt}, 32'd0);
    check("rst_cycle", {16'd0, cycle_cnt}, 32'd0);
    check("rst_err", {30'd0, err, err_s}, 32'd0);
    check("rst_code", {30'd0, err_code}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;

    // R-type: S0 S1 S6 S7
    step(0, OP_RTYPE, 0); step(1, OP_RTYPE, 0); step(6, OP_RTYPE, 0); step(7, OP_RTYPE, 1);
    check("rtype_retire", {16'd0, retire_cnt}, 32'd1);
    check("rtype_err", {31'd0, err}, 32'd0);
    step(0, OP_RTYPE, 0);

    // LW then SW
    do_reset();
    step(0, OP_LW, 0); step(1, OP_LW, 0); step(2, OP_LW, 0); step(3, OP_LW, 0); step(4, OP_LW, 1);
    step(0, OP_SW, 0); step(1, OP_SW, 0); step(2, OP_SW, 0); step(5, OP_SW, 1);
    check("lwsw_retire", {16'd0, retire_cnt}, 32'd2);
    check("lwsw_cycle", {16'd0, cycle_cnt}, 32'd9);
    check("lwsw_err", {31'd0, err}, 32'd0);

    // BEQ decode followed by a jump word: one transition error, then clean
    do_reset();
    step(0, OP_BEQ, 0); step(1, OP_BEQ, 0); step(9, OP_BEQ, 0);
    check("trans_err", {31'd0, err}, 32'd1);
    check("trans_code", {30'd0, err_code}, 32'd2);
    step(0, OP_BEQ, 0);
    check("trans_err_hold", {31'd0, err}, 32'd1);
    check("trans_code_hold", {30'd0, err_code}, 32'd2);
    check("trans_retire", {16'd0, retire_cnt}, 32'd0);

    // Illegal word, then resync on a clean jump
    do_reset();
    step(BAD, OP_RTYPE, 0);
    check("illegal_err", {31'd0, err}, 32'd1);
    check("illegal_code", {30'd0, err_code}, 32'd1);
    step(0, OP_J, 0); step(1, OP_J, 0); step(9, OP_J, 1);
    check("illegal_retire", {16'd0, retire_cnt}, 32'd1);
    check("illegal_code_hold", {30'd0, err_code}, 32'd1);

    // Saturation on the 4-bit instance
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(0, OP_RTYPE, 0); step(1, OP_RTYPE, 0); step(6, OP_RTYPE, 0); step(7, OP_RTYPE, 1);
    end
    check("sat_retire_wide", {16'd0, retire_cnt}, 32'd20);
    check("sat_cycle_wide", {16'd0, cycle_cnt}, 32'd80);
    check("sat_retire_small", {28'd0, retire_cnt_s}, 32'hF);
    check("sat_cycle_small", {28'd0, cycle_cnt_s}, 32'hF);
    check("sat_err", {30'd0, err, err_s}, 32'd0);

    // Asynchronous reset in the middle of a load
    do_reset();
    step(0, OP_LW, 0); step(1, OP_LW, 0); step(2, OP_LW, 0);
    drive_state(3);
    #2 rst = 1'b0;
    #1;
    check("async_state_id", {28'd0, state_id}, 32'hF);
    check("async_valid", {31'd0, state_valid}, 32'd0);
    check("async_cycle", {16'd0, cycle_cnt}, 32'd0);
    check("async_err", {31'd0, err}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    step(0, OP_LW, 0);
    check("post_rst_err", {31'd0, err}, 32'd0);
    check("post_rst_cycle", {16'd0, cycle_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
